// File: rtl/lsu_bus_bridge.sv
// Load/store bridge from the MEM stage to a 64-bit req/gnt/rvalid data bus.
// Define LSU_ALIGN_CHECK_EN to fault misaligned accesses instead of issuing them.
module lsu_bus_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   input  logic        req_we_i,
   input  logic [63:0] req_addr_i,
   input  logic [63:0] req_wdata_i,
   input  logic [2:0]  req_funct3_i,
   output logic        busy_o,
   output logic        rsp_valid_o,
   output logic [63:0] rsp_rdata_o,
   output logic        misalign_o,
   output logic        bus_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [63:0] mem_addr_o,
   output logic [63:0] mem_wdata_o,
   output logic [7:0]  mem_be_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [63:0] mem_rdata_i
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t      state, state_next;
   logic [15:0] cnt, cnt_next;
   logic        we;
   logic [2:0]  funct3;
   logic [2:0]  off;
   logic [60:0] line;
   logic [63:0] wdata_lane;
   logic [7:0]  be;
   logic [63:0] rdata_q, rdata_next;
   logic        misalign_q, misalign_next;
   logic        bus_err_q, bus_err_next;
   logic        busy;
   logic        accept;
   logic        fault;
   logic [3:0]  req_bytes;
   logic [7:0]  req_size_mask;
   logic [7:0]  req_be;
   logic [63:0] rsh;
   logic [63:0] load_data;

   assign accept        = (state == IDLE) && req_valid_i;
   assign req_bytes     = 4'd1 << req_funct3_i[1:0];
   assign req_size_mask = 8'((9'd1 << req_bytes) - 9'd1);
   assign req_be        = req_size_mask << req_addr_i[2:0];

`ifdef LSU_ALIGN_CHECK_EN
   // size-1 is 0/1/3/7, so any offset bit under it breaks natural alignment
   assign fault = |(req_addr_i[2:0] & 3'(req_bytes - 4'd1));
`else
   assign fault = 1'b0;
`endif

   // bytes above the line boundary shift in as zero before extension
   assign rsh = mem_rdata_i >> {off, 3'b000};

   always_comb begin
      case (funct3[1:0])
         2'd0:    load_data = funct3[2] ? {56'd0, rsh[7:0]}  : {{56{rsh[7]}},  rsh[7:0]};
         2'd1:    load_data = funct3[2] ? {48'd0, rsh[15:0]} : {{48{rsh[15]}}, rsh[15:0]};
         2'd2:    load_data = funct3[2] ? {32'd0, rsh[31:0]} : {{32{rsh[31]}}, rsh[31:0]};
         default: load_data = rsh;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         we         <= 1'b0;
         funct3     <= '0;
         off        <= '0;
         line       <= '0;
         wdata_lane <= '0;
         be         <= '0;
      end else if (accept) begin
         we         <= req_we_i;
         funct3     <= req_funct3_i;
         off        <= req_addr_i[2:0];
         line       <= req_addr_i[63:3];
         wdata_lane <= req_wdata_i << {req_addr_i[2:0], 3'b000};
         be         <= req_be;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         cnt        <= '0;
         rdata_q    <= '0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         rdata_q    <= rdata_next;
         misalign_q <= misalign_next;
         bus_err_q  <= bus_err_next;
      end
   end

   // response registers only load on the transition into DONE, so they read 0 elsewhere
   always_comb begin
      state_next    = state;
      cnt_next      = '0;
      rdata_next    = '0;
      misalign_next = 1'b0;
      bus_err_next  = 1'b0;
      busy          = 1'b0;
      case (state)
         IDLE: begin
            busy = req_valid_i;
            if (req_valid_i) begin
               if (fault) begin
                  state_next    = DONE;
                  misalign_next = 1'b1;
               end else begin
                  state_next = REQ;
               end
            end
         end
         REQ: begin
            busy = 1'b1;
            if (mem_gnt_i) begin
               if (mem_rvalid_i) begin
                  state_next = DONE;
                  rdata_next = we ? '0 : load_data;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            busy = 1'b1;
            if (mem_rvalid_i) begin
               state_next = DONE;
               rdata_next = we ? '0 : load_data;
            end else if (cnt == 16'(TIMEOUT_CYCLES)) begin
               state_next   = DONE;
               bus_err_next = 1'b1;
            end else begin
               cnt_next = cnt + 16'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy_o      = busy & ~rst_i;
   assign rsp_valid_o = (state == DONE);
   assign rsp_rdata_o = rdata_q;
   assign misalign_o  = misalign_q;
   assign bus_err_o   = bus_err_q;
   assign mem_req_o   = (state == REQ);
   assign mem_we_o    = mem_req_o & we;
   assign mem_addr_o  = mem_req_o ? {line, 3'b000} : '0;
   assign mem_wdata_o = mem_req_o ? wdata_lane : '0;
   assign mem_be_o    = mem_req_o ? be : '0;
endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Randomized self-checking bench for lsu_bus_bridge against a byte-level reference model.
// Honours LSU_ALIGN_CHECK_EN the same way the design does.
module tb_lsu_bus_bridge;
   localparam int unsigned TMO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [2:0]  req_funct3 = '0;
   logic        busy, rsp_valid, misalign, bus_err;
   logic [63:0] rsp_rdata;
   logic        mem_req, mem_we;
   logic [63:0] mem_addr, mem_wdata;
   logic [7:0]  mem_be;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [63:0] mem_rdata = '0;

   int errors = 0;
   int checks = 0;

   lsu_bus_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .req_funct3_i(req_funct3),
      .busy_o(busy), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
      .misalign_o(misalign), .bus_err_o(bus_err),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
      .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ref_be(input logic [63:0] a, input logic [2:0] f3);
      int unsigned n, o;
      logic [7:0] v;
      n = 1 << f3[1:0];
      o = a[2:0];
      v = '0;
      for (int unsigned i = 0; i < 8; i++) v[i] = (i >= o) && (i < o + n);
      return v;
   endfunction

   function automatic logic [63:0] ref_wdata(input logic [63:0] wd, input logic [63:0] a);
      int unsigned o;
      logic [63:0] v;
      o = a[2:0];
      v = '0;
      for (int unsigned i = 0; i < 8; i++) if (i >= o) v[8*i +: 8] = wd[8*(i-o) +: 8];
      return v;
   endfunction

   function automatic logic [63:0] ref_load(input logic [63:0] rd, input logic [63:0] a, input logic [2:0] f3);
      int unsigned n, o;
      logic [63:0] v;
      n = 1 << f3[1:0];
      o = a[2:0];
      v = '0;
      for (int unsigned k = 0; k < n; k++) if (o + k < 8) v[8*k +: 8] = rd[8*(o+k) +: 8];
      if (!f3[2] && v[8*n-1]) for (int unsigned j = 8*n; j < 64; j++) v[j] = 1'b1;
      return v;
   endfunction

   function automatic logic ref_misaligned(input logic [63:0] a, input logic [2:0] f3);
`ifdef LSU_ALIGN_CHECK_EN
      int unsigned n, o;
      n = 1 << f3[1:0];
      o = a[2:0];
      return (o % n) != 0;
`else
      return (a[0] & 1'b0) | (f3[0] & 1'b0);
`endif
   endfunction

   // gdly: REQ cycles before gnt; rdly: 0 = rvalid with gnt, k = k-th WAIT cycle, >=50 = never
   task automatic do_access(input string name, input logic we, input logic [63:0] addr,
                            input logic [63:0] wd, input logic [2:0] f3,
                            input int unsigned gdly, input int unsigned rdly, input logic [63:0] rd);
      logic        mis, tmo, done, granted, sent;
      logic [63:0] exp_data;
      int unsigned exp_cyc, req_cnt, wait_cnt;
      mis = ref_misaligned(addr, f3);
      tmo = !mis && (rdly >= 50);
      exp_data = (mis || tmo || we) ? 64'd0 : ref_load(rd, addr, f3);
      exp_cyc = mis ? 1 : (tmo ? 2 + gdly + TMO + 1 : 2 + gdly + rdly);
      done = 1'b0; granted = 1'b0; sent = 1'b0; req_cnt = 0; wait_cnt = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_funct3 = f3;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s accept: busy=%b rsp_valid=%b, required busy=1 rsp_valid=0", name, busy, rsp_valid);
      end
      for (int unsigned c = 1; c <= 40 && !done; c++) begin
         @(posedge clk); #1;
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = {$urandom, $urandom};
         if (mem_req) begin
            checks++;
            if (mis) begin
               errors++;
               $display("FAIL %s bus_activity: mem_req=1 on a faulted access, required 0", name);
            end
            checks++;
            if (mem_addr !== {addr[63:3], 3'b000} || mem_be !== ref_be(addr, f3) ||
                mem_we !== we || mem_wdata !== ref_wdata(wd, addr)) begin
               errors++;
               $display("FAIL %s bus_fields: addr=%h be=%h we=%b wdata=%h, required addr=%h be=%h we=%b wdata=%h",
                        name, mem_addr, mem_be, mem_we, mem_wdata,
                        {addr[63:3], 3'b000}, ref_be(addr, f3), we, ref_wdata(wd, addr));
            end
            if (req_cnt == gdly) begin
               mem_gnt = 1'b1;
               granted = 1'b1;
               if (rdly == 0) begin
                  mem_rvalid = 1'b1; mem_rdata = rd; sent = 1'b1;
               end
            end
            req_cnt++;
         end else if (granted && !sent) begin
            wait_cnt++;
            if (wait_cnt == rdly) begin
               mem_rvalid = 1'b1; mem_rdata = rd; sent = 1'b1;
            end
         end
         @(negedge clk);
         if (rsp_valid) begin
            done = 1'b1;
            req_valid = 1'b0;
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            checks++;
            if (c != exp_cyc) begin
               errors++;
               $display("FAIL %s latency: rsp_valid at cycle %0d, required cycle %0d", name, c, exp_cyc);
            end
            checks++;
            if (rsp_rdata !== exp_data || misalign !== mis || bus_err !== tmo || busy !== 1'b0) begin
               errors++;
               $display("FAIL %s response: rdata=%h misalign=%b bus_err=%b busy=%b, required rdata=%h misalign=%b bus_err=%b busy=0",
                        name, rsp_rdata, misalign, bus_err, busy, exp_data, mis, tmo);
            end
         end else begin
            checks++;
            if (busy !== 1'b1 || rsp_rdata !== 64'd0 || misalign !== 1'b0 || bus_err !== 1'b0) begin
               errors++;
               $display("FAIL %s pending: busy=%b rdata=%h misalign=%b bus_err=%b at cycle %0d, required busy=1 and zero response",
                        name, busy, rsp_rdata, misalign, bus_err, c);
            end
         end
      end
      if (!done) begin
         errors++;
         req_valid = 1'b0;
         mem_gnt = 1'b0; mem_rvalid = 1'b0;
         $display("FAIL %s no_response: rsp_valid never rose within 40 cycles, required at cycle %0d", name, exp_cyc);
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 64'd0 || misalign !== 1'b0 ||
          bus_err !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 64'd0 ||
          mem_wdata !== 64'd0 || mem_be !== 8'd0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b rsp_valid=%b rdata=%h mis=%b err=%b req=%b we=%b addr=%h wdata=%h be=%h, required all 0",
                  busy, rsp_valid, rsp_rdata, misalign, bus_err, mem_req, mem_we, mem_addr, mem_wdata, mem_be);
      end
      rst = 1'b0;
   endtask

   task automatic test_plan_vectors;
      do_access("lw_1004", 1'b0, 64'h1004, 64'd0, 3'b010, 0, 1, 64'h8000_0000_1234_5678);
      do_access("sb_2003", 1'b1, 64'h2003, 64'hAB, 3'b000, 3, 2, 64'd0);
      do_access("lhu_3006", 1'b0, 64'h3006, 64'd0, 3'b101, 0, 1, 64'hBEEF_0000_0000_0000);
      do_access("ld_same_cycle", 1'b0, 64'h3008, 64'd0, 3'b011, 0, 0, 64'hFEDC_BA98_7654_3210);
      do_access("lw_1002", 1'b0, 64'h1002, 64'd0, 3'b010, 1, 2, 64'h1122_3344_5566_7788);
      do_access("sd_trunc", 1'b1, 64'h4005, 64'h0102_0304_0506_0708, 3'b011, 0, 1, 64'd0);
   endtask

   task automatic test_timeout;
      do_access("ld_timeout", 1'b0, 64'h5000, 64'd0, 3'b011, 0, 99, 64'hDEAD_BEEF_DEAD_BEEF);
      do_access("sw_timeout", 1'b1, 64'h5104, 64'h1234_5678, 3'b010, 2, 99, 64'd0);
   endtask

   task automatic test_reset_mid;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h6000; req_funct3 = 3'b011;
      @(posedge clk); #1;
      checks++;
      if (mem_req !== 1'b1) begin
         errors++;
         $display("FAIL rst_req setup: mem_req=%b, required 1", mem_req);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (mem_req !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_in_req: mem_req=%b busy=%b, required 0 0", mem_req, busy);
      end
      @(negedge clk);
      rst = 1'b0; req_valid = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_addr = 64'h6008;
      @(posedge clk); #1;
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (mem_req !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_in_wait: mem_req=%b busy=%b rsp_valid=%b, required 0 0 0", mem_req, busy, rsp_valid);
      end
      @(negedge clk);
      rst = 1'b0; req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         mem_rvalid = 1'b1; mem_rdata = {$urandom, $urandom};
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stale_rvalid: rsp_valid=%b busy=%b, required 0 0", rsp_valid, busy);
         end
      end
      mem_rvalid = 1'b0;
      do_access("ld_after_rst", 1'b0, 64'h6010, 64'd0, 3'b011, 1, 1, 64'h0123_4567_89AB_CDEF);
   endtask

   task automatic test_random;
      for (int i = 0; i < 150; i++) begin
         logic        we;
         logic [2:0]  f3;
         logic [63:0] a, wd, rd;
         int unsigned g, r;
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = {$urandom, $urandom};
         wd = {$urandom, $urandom};
         rd = {$urandom, $urandom};
         g  = $urandom_range(0, 3);
         r  = ($urandom_range(0, 9) == 0) ? 99 : $urandom_range(0, 3);
         do_access("random", we, a, wd, f3, g, r, rd);
      end
   endtask

   initial begin
      test_reset();
      test_plan_vectors();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/lsu_bus_bridge.md
# lsu_bus_bridge

Load/store unit between the pipeline's MEM stage and a 64-bit data-memory bus with request/grant/response handshake. Accepts one access from MEM, generates byte enables and lane-shifted store data, stalls the pipeline while the bus is outstanding, and returns sign/zero-extended load data to MEM/WB. It replaces the single-cycle RAM port with a multi-cycle, fault-reporting one.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum WAIT cycles before a bus error is declared (1..65535).
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; asynchronous, active-high.
- `req_valid_i` in 1: MEM stage presents an access.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_addr_i` in 64: byte address.
- `req_wdata_i` in 64: store data, right-aligned.
- `req_funct3_i` in 3: RV64 funct3 (LB/LH/LW/LD/LBU/LHU/LWU; SB/SH/SW/SD).
- `busy_o` out 1: stall request to the pipeline.
- `rsp_valid_o` out 1: one-cycle completion pulse.
- `rsp_rdata_o` out 64: extended load data, valid with `rsp_valid_o`.
- `misalign_o` out 1: misaligned-access fault, valid with `rsp_valid_o`.
- `bus_err_o` out 1: timeout fault, valid with `rsp_valid_o`.
- `mem_req_o` out 1, `mem_we_o` out 1, `mem_addr_o` out 64 (8-byte aligned), `mem_wdata_o` out 64, `mem_be_o` out 8: bus request.
- `mem_gnt_i` in 1, `mem_rvalid_i` in 1, `mem_rdata_i` in 64: bus grant and response (response also acknowledges stores).

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: on `req_valid_i`, latch we/addr/wdata/funct3 and go to REQ. If the fault check (see Configuration) flags the access, go to DONE with `misalign_o` set instead.
- REQ: `mem_req_o`=1 with all bus outputs held stable until `mem_gnt_i`.
  - On gnt, go to WAIT.
  - On gnt and `mem_rvalid_i` in the same cycle, go directly to DONE.
- WAIT: a 16-bit counter starts at 0 and increments each cycle.
  - On `mem_rvalid_i`, capture data and go to DONE.
  - When the counter reaches `TIMEOUT_CYCLES`, go to DONE with `bus_err_o` set and data 0.
- DONE: `rsp_valid_o`=1 for exactly one cycle, then IDLE. `req_valid_i` is ignored in DONE because the same instruction is still in MEM.
- Size: funct3[1:0] gives 1/2/4/8 bytes.
  - `off`=addr[2:0].
  - `mem_be_o`=((1<<size)-1)<<off, truncated to 8 bits.
  - `mem_wdata_o`=wdata<<(8·off).
  - `mem_addr_o`={addr[63:3],3'b000}.
- Loads: shift data = rdata>>(8·off), then extend.
  - funct3[2]=0: sign-extend.
  - funct3[2]=1: zero-extend.
  - funct3 111 is treated as LD.
- Stores use funct3[1:0] only. `rsp_rdata_o`=0 for stores.
- Fault flags and `rsp_rdata_o` are registered. They are 0 whenever `rsp_valid_o`=0.

## Timing
- Reset: state IDLE, counter 0, every output 0.
- Reset mid-transaction returns the FSM to IDLE immediately and drops `mem_req_o` asynchronously. Any later response is ignored.
- `busy_o` = (IDLE & `req_valid_i`) | REQ | WAIT. This is combinational in IDLE and low in DONE, so MEM advances on the `rsp_valid_o` cycle.
- Best-case latency: accept at cycle 0, `mem_req_o` at cycle 1, gnt at cycle 1, rvalid at cycle 2, `rsp_valid_o` at cycle 3.
- Best-case latency with same-cycle gnt+rvalid at cycle 1: `rsp_valid_o` at cycle 2.
- Misalign fault: `rsp_valid_o` at cycle 1; no bus activity.
- `mem_rvalid_i` is ignored in IDLE and DONE, and in REQ unless gnt is also asserted.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - Halfword accesses are misaligned if addr[0]≠0.
  - Word accesses are misaligned if addr[1:0]≠0.
  - Doubleword accesses are misaligned if addr[2:0]≠0.
  - A misaligned access never reaches the bus and completes with `misalign_o`=1.
- `LSU_ALIGN_CHECK_EN` undefined:
  - No check is made; `misalign_o` is tied to 0.
  - Misaligned accesses are issued with byte enables truncated at the 8-byte boundary.
  - Loads return only the in-line bytes, then extend.

## Test plan
- LW addr 0x1004, bus returns rdata 0x8000_0000_1234_5678 with gnt at cycle 1 and rvalid at cycle 2:
  - `mem_addr_o`=0x1000, `mem_be_o`=0xF0.
  - At cycle 3: `rsp_rdata_o`=0xFFFF_FFFF_8000_0000, `rsp_valid_o`=1.
- SB addr 0x2003 wdata 0xAB:
  - `mem_be_o`=0x08, `mem_wdata_o`[31:24]=0xAB, `mem_we_o`=1.
  - gnt delayed 3 cycles: bus outputs stay stable and `busy_o` stays 1 throughout.
- LHU addr 0x3006, rdata 0xBEEF_0000_0000_0000: response 0x0000_0000_0000_BEEF.
- LD with `TIMEOUT_CYCLES`=4, no rvalid: `rsp_valid_o`=1 with `bus_err_o`=1 and data 0, 5 cycles after entering WAIT.
- LW addr 0x1002:
  - With `LSU_ALIGN_CHECK_EN`: `misalign_o`=1 at cycle 1 and `mem_req_o` never rises.
  - Without it: `mem_be_o`=0x3C.
- Assert `rst_i` during WAIT: `mem_req_o` and `busy_o` drop at once. A stale rvalid after reset produces no `rsp_valid_o`. The next LD completes normally.
